tcam_update_ctrl: RTL

TCAM_UPDATE_CTRL -- requirements
Module: tcam_update_ctrl

---
 rtl/fractcam_pkg.sv | 15 +
 rtl/tcam_wdata_gen.sv | 40 ++++
 rtl/tcam_update_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fractcam_pkg.sv
// Shared constants and FSM encoding for the fractured-TCAM update path.
// One LUTRAM slice column covers 5 key bits, so each entry is rewritten over 32 addresses.
package fractcam_pkg;

  localparam int SLICE_WIDTH   = 5;
  localparam int LUT_DEPTH     = 32;
  localparam int SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/tcam_wdata_gen.sv
// Per-column LUTRAM write data: a column bit is 1 when LUT address cnt matches the
// masked 5-bit key slice of that column.
module tcam_wdata_gen
  import fractcam_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int COLS  = 2
) (
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] mask,
  input  logic             del_en,
  input  logic [4:0]       cnt,
  output logic [COLS-1:0]  wdata
);

  localparam int PW = COLS * SLICE_WIDTH;

  logic [PW-1:0] key_pad_s;
  logic [PW-1:0] mask_pad_s;

  // Zero-extension leaves the padded mask bits at 0, so padded positions always match.
  always_comb begin
    key_pad_s  = PW'(key);
    mask_pad_s = PW'(mask);
  end

  // Match of every LUT address against each masked key slice.
  always_comb begin
    wdata = '0;
    for (int c = 0; c < COLS; c++) begin
      if (del_en) begin
        wdata[c] = 1'b0;
      end else begin
        wdata[c] = (((cnt ^ key_pad_s[c*SLICE_WIDTH +: SLICE_WIDTH]) &
                     mask_pad_s[c*SLICE_WIDTH +: SLICE_WIDTH]) == 5'd0);
      end
    end
  end

endmodule

// File: rtl/tcam_update_ctrl.sv
// Update controller for a LUTRAM-based TCAM: rewrites one entry over 32 LUT addresses,
// then settles one cycle, arbitrating TCAM access with a search requester.
module tcam_update_ctrl
  import fractcam_pkg::*;
#(
  parameter int  WIDTH = 10,
  parameter int  DEPTH = 64,
  localparam int COLS  = (WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IW-1:0]    wr_index,
  input  logic [WIDTH-1:0] wr_key,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             wr_delete,
  input  logic             srch_valid,
  output logic             srch_grant,
  output logic [4:0]       lut_waddr,
  output logic [COLS-1:0]  lut_wdata,
  output logic [DEPTH-1:0] lut_we,
  output logic             busy,
  output logic             err_index
);

  localparam logic [IW:0] DEPTH_W     = (IW + 1)'(DEPTH);
  localparam logic [4:0]  CNT_LAST    = 5'(LUT_DEPTH - 1);
  localparam logic [4:0]  SETTLE_LAST = 5'(SETTLE_CYCLES - 1);

  state_e           state_r;
  state_e           state_s;
  logic [4:0]       cnt_r;
  logic             fair_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] key_r;
  logic [WIDTH-1:0] mask_r;
  logic             del_r;

  logic             ready_s;
  logic             grant_s;
  logic             hs_s;
  logic             in_write_s;
  logic             idx_ok_s;
  logic [COLS-1:0]  gen_wdata_s;

  // Next-state and arbitration; the write side wins unless a search is owed a turn.
  always_comb begin
    state_s = state_r;
    ready_s = 1'b0;
    grant_s = 1'b0;
    hs_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst) begin
          ready_s = 1'b0;
          grant_s = 1'b0;
        end else begin
          ready_s = !(fair_r && srch_valid);
          hs_s    = wr_valid && ready_s;
          grant_s = srch_valid && !hs_s;
        end
        if (hs_s) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = SETTLE;
        end else begin
          state_s = WRITE;
        end
      end
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = SETTLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, phase counter and search fairness flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      fair_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_s == state_r) && (state_r != IDLE)) begin
        cnt_r <= cnt_r + 5'd1;
      end else begin
        cnt_r <= 5'd0;
      end
      if ((state_r == WRITE) && (state_s == SETTLE)) begin
        fair_r <= 1'b1;
      end else if ((state_r == IDLE) && (grant_s || !srch_valid)) begin
        fair_r <= 1'b0;
      end else begin
        fair_r <= fair_r;
      end
    end
  end

  // Capture of the accepted update request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r  <= '0;
      key_r  <= '0;
      mask_r <= '0;
      del_r  <= 1'b0;
    end else if (hs_s) begin
      idx_r  <= wr_index;
      key_r  <= wr_key;
      mask_r <= wr_mask;
      del_r  <= wr_delete;
    end else begin
      idx_r  <= idx_r;
      key_r  <= key_r;
      mask_r <= mask_r;
      del_r  <= del_r;
    end
  end

  tcam_wdata_gen #(
    .WIDTH (WIDTH),
    .COLS  (COLS)
  ) u_wdata_gen (
    .key    (key_r),
    .mask   (mask_r),
    .del_en (del_r),
    .cnt    (cnt_r),
    .wdata  (gen_wdata_s)
  );

  assign in_write_s = (state_r == WRITE);
  assign idx_ok_s   = ({1'b0, idx_r} < DEPTH_W);

  // LUTRAM write port is quiet outside WRITE; an out-of-range index writes nothing.
  always_comb begin
    if (in_write_s) begin
      lut_waddr = cnt_r;
      lut_wdata = gen_wdata_s;
    end else begin
      lut_waddr = 5'd0;
      lut_wdata = '0;
    end
    if (in_write_s && idx_ok_s) begin
      lut_we = DEPTH'(1) << idx_r;
    end else begin
      lut_we = '0;
    end
  end

  assign wr_ready   = ready_s;
  assign srch_grant = grant_s;
  assign busy       = (state_r != IDLE);
  assign err_index  = in_write_s && (cnt_r == 5'd0) && !idx_ok_s;

endmodule
